// File: rtl/uart_tx_queue_pkg.sv
// Shared types and defaults for the UART transmit queue.
package uart_tx_queue_pkg;

  localparam int unsigned TXQ_DATABITS_DEF = 8;
  localparam int unsigned TXQ_DEPTH_DEF    = 16;

  // Handshake FSM with uart_send.
  // state   | meaning
  // ST_SYNC | one cycle after reset: copy ack into seq, no pop
  // ST_IDLE | seq==ack, uart_send idle; pop a stored byte if any
  // ST_BUSY | byte in flight, data held; wait for ack to catch up with seq
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } txq_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port.
module uart_fifo_ram #(
  parameter int unsigned DATABITS = 8,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATABITS-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATABITS-1:0]        rdata_o
);

  logic [DATABITS-1:0] mem_q [DEPTH];

  // Store the incoming byte; contents need no reset since level gates every read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding uart_send over its seq/ack toggle handshake.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DATABITS = TXQ_DATABITS_DEF,
  parameter int unsigned DEPTH    = TXQ_DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [DATABITS-1:0]        wr_data_i,
  input  logic                       wr_en_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  input  logic                       flush_i,
  output logic [DATABITS-1:0]        data_o,
  output logic                       seq_o,
  input  logic                       ack_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ZERO = '0;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  txq_state_e          state_q, state_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic [PW-1:0]       wr_q, wr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                overflow_q, overflow_d;
  logic                seq_q, seq_d;
  logic [DATABITS-1:0] data_q, data_d;

  logic                full;
  logic                wr_accept;
  logic                pop;
  logic [DATABITS-1:0] rd_data;

  // full is taken from the registered level, so a pop on the same edge
  // does not make room for a write that arrives while full.
  assign full      = (level_q == LVL_FULL);
  assign wr_accept = wr_en_i && !full && !flush_i;

  uart_fifo_ram #(
    .DATABITS(DATABITS),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (wr_accept),
    .waddr_i(wr_q),
    .wdata_i(wr_data_i),
    .raddr_i(rd_q),
    .rdata_o(rd_data)
  );

  // Handshake FSM: decides when to pop and launch the next byte.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        seq_d   = ack_i;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if ((level_q != LVL_ZERO) && !flush_i) begin
          pop     = 1'b1;
          data_d  = rd_data;
          seq_d   = ~seq_q;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ack_i == seq_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // Pointer, level and overflow bookkeeping; flush wins over write and pop.
  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (wr_en_i && full) begin
      overflow_d = 1'b1;
    end
    if (flush_i) begin
      level_d = LVL_ZERO;
      rd_d    = wr_q;
    end else begin
      if (wr_accept) begin
        wr_d = wr_q + PTR_ONE;
      end
      if (pop) begin
        rd_d = rd_q + PTR_ONE;
      end
      level_d = level_q + LW'(wr_accept) - LW'(pop);
    end
  end

  // State register for the FSM and the queue bookkeeping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_SYNC;
      rd_q       <= '0;
      wr_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      seq_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      seq_q      <= seq_d;
      data_q     <= data_d;
    end
  end

  assign full_o     = full;
  assign empty_o    = (level_q == LVL_ZERO) && (state_q != ST_BUSY);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign data_o     = data_q;
  assign seq_o      = seq_q;

endmodule
